// File: rtl/down_counter_sync_rst_pkg.sv
// Shared types and defaults for the loadable down-counter.
//   state_t      : control FSM encoding (IDLE, RUN, DONE)
//   DefaultWidth : default counter width (legal range 2..16)
// Optional build macro DOWN_CNT_STICKY_DONE_EN is consumed by the interface and the top.
package down_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DefaultWidth      = 4;
  localparam int unsigned DefaultAutoReload = 0;

endpackage

// File: rtl/down_counter_sync_rst_if.sv
// Control/status bundle for down_counter_sync_rst.
//   master : controller side, drives load/load_val/start/en/abort (and done_ack),
//            observes count/busy/tc/done
//   slave  : counter side, the mirror of master
// With DOWN_CNT_STICKY_DONE_EN defined the bundle carries done_ack; otherwise it is absent.
interface down_counter_sync_rst_if #(
  parameter int unsigned WIDTH = down_counter_pkg::DefaultWidth
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             en;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;
`ifdef DOWN_CNT_STICKY_DONE_EN
  logic             done_ack;

  modport master (output load, load_val, start, en, abort, done_ack,
                  input  count, busy, tc, done);
  modport slave  (input  load, load_val, start, en, abort, done_ack,
                  output count, busy, tc, done);
`else
  modport master (output load, load_val, start, en, abort,
                  input  count, busy, tc, done);
  modport slave  (input  load, load_val, start, en, abort,
                  output count, busy, tc, done);
`endif
endinterface

// File: rtl/down_counter_sync_rst.sv
// Loadable down-counter with IDLE/RUN/DONE control FSM and synchronous active-high reset.
// Ports:
//   clk_i   : rising-edge clock
//   reset_i : synchronous active-high reset (highest priority)
//   bus     : down_counter_sync_rst_if.slave
//             in : load, load_val, start, en, abort (+ done_ack when sticky)
//             out: count, busy (registered), tc (combinational count == 0), done (registered)
// Parameters: WIDTH (2..16), AUTO_RELOAD (1 = reload and keep running on reaching zero).
// Build macro DOWN_CNT_STICKY_DONE_EN: done becomes sticky, cleared by load, abort, reset
// or done_ack (done_ack beats a same-cycle set). Undefined: done is a 1-cycle pulse.
module down_counter_sync_rst
  import down_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned AUTO_RELOAD = DefaultAutoReload
) (
  input logic                    clk_i,
  input logic                    reset_i,
  down_counter_sync_rst_if.slave bus
);

  localparam logic [WIDTH-1:0] CountOne = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             set_done;
  logic             load_taken;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    set_done   = 1'b0;
    load_taken = 1'b0;
    // abort outranks everything but reset, and swallows any done set on this edge
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.load) begin
            count_d    = bus.load_val;
            reload_d   = bus.load_val;
            load_taken = 1'b1;
          end else if (bus.start) begin
            if (count_q == '0) begin
              state_d  = DONE;
              set_done = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          // load is ignored here; RUN always holds a non-zero count
          if (bus.en) begin
            if (count_q == CountOne) begin
              set_done = 1'b1;
              if (AUTO_RELOAD != 0) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
            end else begin
              count_d = count_q - CountOne;
            end
          end
        end
        DONE: begin
          // start alone cannot re-arm; a load must come first
          if (bus.load) begin
            count_d    = bus.load_val;
            reload_d   = bus.load_val;
            load_taken = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN);

`ifdef DOWN_CNT_STICKY_DONE_EN
    done_d = done_q;
    if (set_done) done_d = 1'b1;
    if (bus.abort || load_taken || bus.done_ack) done_d = 1'b0;
`else
    done_d = set_done;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.tc    = (count_q == '0);
  assign bus.done  = done_q;

  // Decrementing below zero must be unreachable: RUN never holds a zero count.
  a_no_underflow : assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q == RUN) |-> (count_q != '0));

endmodule
